// File: rtl/beehive_tx_sched_pkg.sv
// Shared definitions for the Beehive MAC TX scheduler.
//   state_e       : grant state of the output port
//   SRC_BYP/APP   : source encodings used for pref and frame_src
//   select_grant  : next grant at a frame boundary
package beehive_tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_APP = 2'd1,
        GNT_BYP = 2'd2
    } state_e;

    localparam logic SRC_BYP = 1'b0;
    localparam logic SRC_APP = 1'b1;

    // Strict mode always looks at app first; otherwise whoever holds the
    // turn is looked at first and the other source fills in when idle.
    function automatic state_e select_grant(input logic strict,
                                            input logic pref,
                                            input logic app_v,
                                            input logic byp_v);
        logic app_first;
        app_first = strict || (pref == SRC_APP);
        if (app_first) begin
            return app_v ? GNT_APP : (byp_v ? GNT_BYP : IDLE);
        end
        return byp_v ? GNT_BYP : (app_v ? GNT_APP : IDLE);
    endfunction

endpackage

// File: rtl/beehive_tx_sched_credit.sv
// Weighted round-robin turn keeper for the TX scheduler.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   frame_done_i/frame_src_i : a frame finished this cycle, and on which source
//   app_weight_i/byp_weight_i: frames per turn (0 behaves as 1)
//   strict_i                 : app strict priority, credits frozen
//   pref_o                   : whose turn it is, already including this
//                              cycle's frame end (feeds the same-cycle
//                              selection so back-to-back frames need no bubble)
module beehive_tx_sched_credit
    import beehive_tx_sched_pkg::*;
#(
    parameter int WEIGHT_W = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                frame_done_i,
    input  logic                frame_src_i,
    input  logic [WEIGHT_W-1:0] app_weight_i,
    input  logic [WEIGHT_W-1:0] byp_weight_i,
    input  logic                strict_i,
    output logic                pref_o
);

    logic                pref_q, pref_d;
    logic [WEIGHT_W-1:0] credit_app_q, credit_app_d;
    logic [WEIGHT_W-1:0] credit_byp_q, credit_byp_d;

    function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [WEIGHT_W-1:0] w);
        return (w == '0) ? WEIGHT_W'(1) : w;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pref_q       <= SRC_APP;
            credit_app_q <= WEIGHT_W'(1);
            credit_byp_q <= WEIGHT_W'(1);
        end else begin
            pref_q       <= pref_d;
            credit_app_q <= credit_app_d;
            credit_byp_q <= credit_byp_d;
        end
    end

    // Only a frame taken on its own turn consumes credit; fill frames from
    // the other source are free. Weights are sampled only at reload, so a
    // config change lands at the start of the next turn.
    always_comb begin
        pref_d       = pref_q;
        credit_app_d = credit_app_q;
        credit_byp_d = credit_byp_q;
        if (frame_done_i && !strict_i && (frame_src_i == pref_q)) begin
            if (pref_q == SRC_APP) begin
                if (credit_app_q <= WEIGHT_W'(1)) begin
                    credit_app_d = eff_weight(app_weight_i);
                    pref_d       = SRC_BYP;
                end else begin
                    credit_app_d = credit_app_q - WEIGHT_W'(1);
                end
            end else begin
                if (credit_byp_q <= WEIGHT_W'(1)) begin
                    credit_byp_d = eff_weight(byp_weight_i);
                    pref_d       = SRC_APP;
                end else begin
                    credit_byp_d = credit_byp_q - WEIGHT_W'(1);
                end
            end
        end
    end

    assign pref_o = pref_d;

endmodule

// File: rtl/beehive_tx_sched.sv
// Frame-atomic weighted round-robin scheduler for the shared MAC TX stream.
//   clk, rst_n           : clock, asynchronous active-low reset
//   cfg_app/byp_weight   : frames per turn for each source (0 behaves as 1)
//   cfg_strict_app       : app preferred at every frame boundary
//   s_app_* / s_byp_*    : AXI-Stream sources (app = port 1, bypass = port 0)
//   m_*                  : AXI-Stream output to the MAC, zero-latency mux
//   stat_app/byp_frames  : completed frames per source, wrapping
//   busy                 : a grant is held
module beehive_tx_sched
    import beehive_tx_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1,
    parameter int WEIGHT_W   = 4,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WEIGHT_W-1:0]   cfg_app_weight,
    input  logic [WEIGHT_W-1:0]   cfg_byp_weight,
    input  logic                  cfg_strict_app,
    input  logic                  s_app_tvalid,
    output logic                  s_app_tready,
    input  logic [DATA_WIDTH-1:0] s_app_tdata,
    input  logic [KEEP_WIDTH-1:0] s_app_tkeep,
    input  logic                  s_app_tlast,
    input  logic [USER_WIDTH-1:0] s_app_tuser,
    input  logic                  s_byp_tvalid,
    output logic                  s_byp_tready,
    input  logic [DATA_WIDTH-1:0] s_byp_tdata,
    input  logic [KEEP_WIDTH-1:0] s_byp_tkeep,
    input  logic                  s_byp_tlast,
    input  logic [USER_WIDTH-1:0] s_byp_tuser,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [KEEP_WIDTH-1:0] m_tkeep,
    output logic                  m_tlast,
    output logic [USER_WIDTH-1:0] m_tuser,
    output logic [CNT_W-1:0]      stat_app_frames,
    output logic [CNT_W-1:0]      stat_byp_frames,
    output logic                  busy
);

    state_e           state_q, state_d;
    logic             in_frame_q, in_frame_d;
    logic [CNT_W-1:0] stat_app_q, stat_app_d;
    logic [CNT_W-1:0] stat_byp_q, stat_byp_d;

    logic app_hs, byp_hs, app_end, byp_end;
    logic frame_done, frame_src, pref_eff;
    state_e sel;

    assign app_hs     = (state_q == GNT_APP) && s_app_tvalid && m_tready;
    assign byp_hs     = (state_q == GNT_BYP) && s_byp_tvalid && m_tready;
    assign app_end    = app_hs && s_app_tlast;
    assign byp_end    = byp_hs && s_byp_tlast;
    assign frame_done = app_end || byp_end;
    assign frame_src  = app_end ? SRC_APP : SRC_BYP;

    beehive_tx_sched_credit #(
        .WEIGHT_W (WEIGHT_W)
    ) u_credit (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .frame_done_i (frame_done),
        .frame_src_i  (frame_src),
        .app_weight_i (cfg_app_weight),
        .byp_weight_i (cfg_byp_weight),
        .strict_i     (cfg_strict_app),
        .pref_o       (pref_eff)
    );

    assign sel = select_grant(cfg_strict_app, pref_eff, s_app_tvalid, s_byp_tvalid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_frame_q <= 1'b0;
            stat_app_q <= '0;
            stat_byp_q <= '0;
        end else begin
            state_q    <= state_d;
            in_frame_q <= in_frame_d;
            stat_app_q <= stat_app_d;
            stat_byp_q <= stat_byp_d;
        end
    end

    // At a frame end the ending source's tvalid is still high, so it may be
    // re-granted. If that source then has nothing to send before its next
    // frame starts, the grant is re-arbitrated instead of being held idle;
    // in_frame_q keeps mid-frame gaps in tvalid from releasing the grant.
    always_comb begin
        state_d    = state_q;
        in_frame_d = in_frame_q;
        unique case (state_q)
            IDLE: begin
                state_d = sel;
            end
            GNT_APP: begin
                if (app_end) begin
                    state_d    = sel;
                    in_frame_d = 1'b0;
                end else if (app_hs) begin
                    in_frame_d = 1'b1;
                end else if (!in_frame_q && !s_app_tvalid) begin
                    state_d = sel;
                end
            end
            GNT_BYP: begin
                if (byp_end) begin
                    state_d    = sel;
                    in_frame_d = 1'b0;
                end else if (byp_hs) begin
                    in_frame_d = 1'b1;
                end else if (!in_frame_q && !s_byp_tvalid) begin
                    state_d = sel;
                end
            end
            default: begin
                state_d    = IDLE;
                in_frame_d = 1'b0;
            end
        endcase
    end

    assign stat_app_d = stat_app_q + CNT_W'(app_end);
    assign stat_byp_d = stat_byp_q + CNT_W'(byp_end);

    always_comb begin
        m_tvalid     = 1'b0;
        m_tdata      = '0;
        m_tkeep      = '0;
        m_tlast      = 1'b0;
        m_tuser      = '0;
        s_app_tready = 1'b0;
        s_byp_tready = 1'b0;
        unique case (state_q)
            GNT_APP: begin
                m_tvalid     = s_app_tvalid;
                m_tdata      = s_app_tdata;
                m_tkeep      = s_app_tkeep;
                m_tlast      = s_app_tlast;
                m_tuser      = s_app_tuser;
                s_app_tready = m_tready;
            end
            GNT_BYP: begin
                m_tvalid     = s_byp_tvalid;
                m_tdata      = s_byp_tdata;
                m_tkeep      = s_byp_tkeep;
                m_tlast      = s_byp_tlast;
                m_tuser      = s_byp_tuser;
                s_byp_tready = m_tready;
            end
            default: begin
            end
        endcase
    end

    assign stat_app_frames = stat_app_q;
    assign stat_byp_frames = stat_byp_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_beehive_tx_sched.sv
module tb_beehive_tx_sched;

    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int UW = 1;
    localparam int WW = 4;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [WW-1:0] cfg_app_weight, cfg_byp_weight;
    logic          cfg_strict_app;
    logic          s_app_tvalid, s_app_tready, s_app_tlast;
    logic [DW-1:0] s_app_tdata;
    logic [KW-1:0] s_app_tkeep;
    logic [UW-1:0] s_app_tuser;
    logic          s_byp_tvalid, s_byp_tready, s_byp_tlast;
    logic [DW-1:0] s_byp_tdata;
    logic [KW-1:0] s_byp_tkeep;
    logic [UW-1:0] s_byp_tuser;
    logic          m_tvalid, m_tready, m_tlast;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [UW-1:0] m_tuser;
    logic [CW-1:0] stat_app_frames, stat_byp_frames;
    logic          busy;

    always #5 clk = ~clk;

    beehive_tx_sched #(
        .DATA_WIDTH (DW), .KEEP_WIDTH (KW), .USER_WIDTH (UW),
        .WEIGHT_W (WW), .CNT_W (CW)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .cfg_app_weight (cfg_app_weight), .cfg_byp_weight (cfg_byp_weight),
        .cfg_strict_app (cfg_strict_app),
        .s_app_tvalid (s_app_tvalid), .s_app_tready (s_app_tready),
        .s_app_tdata (s_app_tdata), .s_app_tkeep (s_app_tkeep),
        .s_app_tlast (s_app_tlast), .s_app_tuser (s_app_tuser),
        .s_byp_tvalid (s_byp_tvalid), .s_byp_tready (s_byp_tready),
        .s_byp_tdata (s_byp_tdata), .s_byp_tkeep (s_byp_tkeep),
        .s_byp_tlast (s_byp_tlast), .s_byp_tuser (s_byp_tuser),
        .m_tvalid (m_tvalid), .m_tready (m_tready), .m_tdata (m_tdata),
        .m_tkeep (m_tkeep), .m_tlast (m_tlast), .m_tuser (m_tuser),
        .stat_app_frames (stat_app_frames), .stat_byp_frames (stat_byp_frames),
        .busy (busy)
    );

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    beat_t app_beats[$];
    beat_t byp_beats[$];
    beat_t exp_q[$];

    int   n_cmp = 0;
    int   n_err = 0;
    int   idle_cnt = 0;
    logic app_hs = 1'b0;
    logic byp_hs = 1'b0;
    bit   tog_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got timeout expected event", nm);
    endtask

    function automatic logic [DW-1:0] mk_data(input bit app, input int id, input int b);
        return (app ? 32'hA000_0000 : 32'hB000_0000) | DW'(id << 8) | DW'(b);
    endfunction

    task automatic push_src(input bit app, input int id, input int nb);
        beat_t bt;
        for (int b = 0; b < nb; b++) begin
            bt.data = mk_data(app, id, b);
            bt.last = (b == nb - 1);
            if (app) app_beats.push_back(bt);
            else     byp_beats.push_back(bt);
        end
    endtask

    task automatic push_exp(input bit app, input int id, input int nb);
        beat_t bt;
        for (int b = 0; b < nb; b++) begin
            bt.data = mk_data(app, id, b);
            bt.last = (b == nb - 1);
            exp_q.push_back(bt);
        end
    endtask

    task automatic wait_neg();
        @(negedge clk);
        #1;
    endtask

    // App source driver: advances on a handshake seen at the previous negedge.
    initial begin
        s_app_tvalid = 1'b0; s_app_tdata = '0; s_app_tkeep = '1;
        s_app_tlast = 1'b0; s_app_tuser = '0;
        forever begin
            @(posedge clk);
            #1;
            if (app_hs && app_beats.size() > 0) void'(app_beats.pop_front());
            if (app_beats.size() > 0) begin
                s_app_tvalid = 1'b1;
                s_app_tdata  = app_beats[0].data;
                s_app_tlast  = app_beats[0].last;
                s_app_tuser  = app_beats[0].data[0];
            end else begin
                s_app_tvalid = 1'b0;
            end
        end
    end

    initial begin
        s_byp_tvalid = 1'b0; s_byp_tdata = '0; s_byp_tkeep = '1;
        s_byp_tlast = 1'b0; s_byp_tuser = '0;
        forever begin
            @(posedge clk);
            #1;
            if (byp_hs && byp_beats.size() > 0) void'(byp_beats.pop_front());
            if (byp_beats.size() > 0) begin
                s_byp_tvalid = 1'b1;
                s_byp_tdata  = byp_beats[0].data;
                s_byp_tlast  = byp_beats[0].last;
                s_byp_tuser  = byp_beats[0].data[0];
            end else begin
                s_byp_tvalid = 1'b0;
            end
        end
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = tog_en ? ~m_tready : 1'b1;
        end
    end

    // Monitor / scoreboard
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            app_hs = s_app_tvalid && s_app_tready;
            byp_hs = s_byp_tvalid && s_byp_tready;
            if (!m_tvalid) idle_cnt++;
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    timeout("unexpected_beat");
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {31'd0, m_tuser, m_tlast, m_tdata},
                        {31'd0, e.data[0], e.last, e.data});
                end
            end
        end
    end

    task automatic drain(input string nm);
        int k;
        for (k = 0; k < 300; k++) begin
            if (exp_q.size() == 0 && app_beats.size() == 0 && byp_beats.size() == 0) break;
            wait_neg();
        end
        if (k == 300) timeout(nm);
        wait_neg();
        wait_neg();
    endtask

    task automatic wait_mvalid(input string nm);
        int k;
        for (k = 0; k < 20; k++) begin
            if (m_tvalid) break;
            wait_neg();
        end
        if (k == 20) timeout(nm);
    endtask

    task automatic do_reset(input logic [WW-1:0] aw, input logic [WW-1:0] bw, input logic st);
        wait_neg();
        rst_n = 1'b0;
        cfg_app_weight = aw;
        cfg_byp_weight = bw;
        cfg_strict_app = st;
        exp_q.delete(); app_beats.delete(); byp_beats.delete();
        wait_neg();
        wait_neg();
        rst_n = 1'b1;
        wait_neg();
    endtask

    initial begin
        int i0, bad, k;
        rst_n = 1'b0;
        cfg_app_weight = 4'd1; cfg_byp_weight = 4'd1; cfg_strict_app = 1'b0;
        wait_neg();
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_treadys", {s_app_tready, s_byp_tready}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stats", {stat_app_frames, stat_byp_frames}, 0);
        do_reset(4'd1, 4'd1, 1'b0);

        // T1: lone app 3-beat frame, one cycle of arbitration latency
        push_src(1, 1, 3); push_exp(1, 1, 3);
        i0 = 0;
        wait_neg();
        chk("t1_valid_seen", s_app_tvalid, 1);
        chk("t1_idle_tready", {busy, s_app_tready}, 0);
        wait_neg();
        chk("t1_grant", {busy, s_app_tready}, 2'b11);
        for (k = 0; k < 6; k++) begin
            if (s_byp_tready) i0++;
            wait_neg();
        end
        chk("t1_byp_tready_low", i0, 0);
        drain("t1_drain");
        chk("t1_stat_app", stat_app_frames, 1);
        chk("t1_stat_byp", stat_byp_frames, 0);
        chk("t1_busy_end", busy, 0);

        // T2: saturated, weights 3/1 -> A,B,A,A,A,B,A,A,A,B
        do_reset(4'd3, 4'd1, 1'b0);
        push_src(1, 0, 1); push_src(1, 1, 1); push_src(1, 2, 1); push_src(1, 3, 1);
        push_src(1, 4, 1); push_src(1, 5, 1); push_src(1, 6, 1);
        push_src(0, 0, 1); push_src(0, 1, 1); push_src(0, 2, 1);
        push_exp(1, 0, 1); push_exp(0, 0, 1);
        push_exp(1, 1, 1); push_exp(1, 2, 1); push_exp(1, 3, 1); push_exp(0, 1, 1);
        push_exp(1, 4, 1); push_exp(1, 5, 1); push_exp(1, 6, 1); push_exp(0, 2, 1);
        wait_mvalid("t2_first");
        i0 = idle_cnt;
        for (k = 0; k < 9; k++) wait_neg();
        chk("t2_no_bubble", idle_cnt - i0, 0);
        drain("t2_drain");
        chk("t2_stats", {stat_app_frames, stat_byp_frames}, {32'd7, 32'd3});

        // T3: byp arrives mid app frame, follows with no bubble
        do_reset(4'd1, 4'd1, 1'b0);
        push_src(1, 3, 4); push_exp(1, 3, 4);
        wait_mvalid("t3_first");
        i0 = idle_cnt;
        wait_neg();
        push_src(0, 3, 2); push_exp(0, 3, 2);
        for (k = 0; k < 4; k++) wait_neg();
        chk("t3_no_bubble", idle_cnt - i0, 0);
        drain("t3_drain");
        chk("t3_stats", {stat_app_frames, stat_byp_frames}, {32'd1, 32'd1});

        // T4: strict app priority starves byp until app goes idle
        do_reset(4'd1, 4'd1, 1'b1);
        push_src(1, 0, 1); push_src(1, 1, 1); push_src(1, 2, 1); push_src(1, 3, 1);
        push_src(0, 4, 1); push_src(0, 5, 1);
        push_exp(1, 0, 1); push_exp(1, 1, 1); push_exp(1, 2, 1); push_exp(1, 3, 1);
        push_exp(0, 4, 1); push_exp(0, 5, 1);
        for (k = 0; k < 30; k++) begin
            if (stat_app_frames == 4) break;
            wait_neg();
        end
        if (k == 30) timeout("t4_app_done");
        chk("t4_byp_starved", stat_byp_frames, 0);
        drain("t4_drain");
        chk("t4_stats", {stat_app_frames, stat_byp_frames}, {32'd4, 32'd2});

        // T5: m_tready toggling over a 4-beat byp frame, app waits for tlast
        do_reset(4'd1, 4'd1, 1'b0);
        push_src(0, 5, 4); push_exp(0, 5, 4); push_exp(1, 5, 1);
        tog_en = 1'b1;
        for (k = 0; k < 20; k++) begin
            if (busy) break;
            wait_neg();
        end
        if (k == 20) timeout("t5_grant");
        push_src(1, 5, 1);
        bad = 0;
        for (k = 0; k < 40; k++) begin
            if (stat_byp_frames == 1) break;
            if (s_app_tready || (s_byp_tready != m_tready)) bad++;
            wait_neg();
        end
        if (k == 40) timeout("t5_frame_end");
        chk("t5_grant_held", bad, 0);
        tog_en = 1'b0;
        drain("t5_drain");
        chk("t5_stats", {stat_app_frames, stat_byp_frames}, {32'd1, 32'd1});

        // T6: asynchronous reset mid-frame
        push_src(1, 6, 4); push_exp(1, 6, 4);
        for (k = 0; k < 20; k++) begin
            if (exp_q.size() <= 2) break;
            wait_neg();
        end
        if (k == 20) timeout("t6_mid_frame");
        chk("t6_mid_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_mvalid", m_tvalid, 0);
        chk("t6_async_treadys", {s_app_tready, s_byp_tready}, 0);
        chk("t6_async_stats", {stat_app_frames, stat_byp_frames}, 0);
        chk("t6_async_busy", busy, 0);
        exp_q.delete(); app_beats.delete(); byp_beats.delete();
        wait_neg();
        wait_neg();
        rst_n = 1'b1;
        wait_neg();
        push_src(0, 7, 1); push_src(1, 7, 1);
        push_exp(1, 7, 1); push_exp(0, 7, 1);
        drain("t6_drain");
        chk("t6_stats", {stat_app_frames, stat_byp_frames}, {32'd1, 32'd1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
